// File: rtl/lock_access_sequencer_if.sv
// Front-panel / datapath signal bundle for lock_access_sequencer.
// master: front panel + datapath side (drives buttons and LOCK_IN, observes strobes).
// slave : the sequencer (observes buttons and LOCK_IN, drives strobes and status).
//   OPEN_BTN/CLOSE_BTN/SET_BTN : raw button levels
//   KEY_ACT                    : any digit key pressed (activity)
//   LOCK_IN                    : datapath LOCK flag
//   OPEN_P/CLOSE_P/SET_P       : one-cycle strobes to the datapath
//   LOCKOUT/ALARM/FAIL_CNT     : status
interface lock_access_sequencer_if #(
    parameter int unsigned MAX_TRIES = 3
);
    localparam int unsigned CNT_W = $clog2(MAX_TRIES + 1);

    logic             OPEN_BTN;
    logic             CLOSE_BTN;
    logic             SET_BTN;
    logic             KEY_ACT;
    logic             LOCK_IN;
    logic             OPEN_P;
    logic             CLOSE_P;
    logic             SET_P;
    logic             LOCKOUT;
    logic             ALARM;
    logic [CNT_W-1:0] FAIL_CNT;

    modport master (
        output OPEN_BTN, CLOSE_BTN, SET_BTN, KEY_ACT, LOCK_IN,
        input  OPEN_P, CLOSE_P, SET_P, LOCKOUT, ALARM, FAIL_CNT
    );

    modport slave (
        input  OPEN_BTN, CLOSE_BTN, SET_BTN, KEY_ACT, LOCK_IN,
        output OPEN_P, CLOSE_P, SET_P, LOCKOUT, ALARM, FAIL_CNT
    );
endinterface

// File: rtl/lock_access_sequencer.sv
// Keypad lock access sequencer: converts raw OPEN/CLOSE/SET button levels into
// single-cycle strobes for the lock datapath, counts consecutive failed opens,
// enforces a timed lockout after MAX_TRIES failures and auto-relocks after idle time.
// Ports:
//   CLK   : clock, posedge
//   RESET : synchronous active-high reset
//   bus   : lock_access_sequencer_if.slave (buttons, KEY_ACT, LOCK_IN in;
//           OPEN_P/CLOSE_P/SET_P strobes, LOCKOUT, ALARM, FAIL_CNT out)
// Build option: define LOCK_ACCESS_ALARM_EN to replace the timed lockout with a
// sticky ALARM state that only RESET clears.
module lock_access_sequencer #(
    parameter int unsigned MAX_TRIES         = 3,
    parameter int unsigned PENALTY_CYCLES    = 1000,
    parameter int unsigned AUTO_CLOSE_CYCLES = 5000,
    parameter int unsigned TMR_W             = 16
) (
    input logic                    CLK,
    input logic                    RESET,
    lock_access_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_PENALTY  = 3'd3
`ifdef LOCK_ACCESS_ALARM_EN
        , ST_ALARM  = 3'd4
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] fail_q, fail_d, fail_inc;
    logic             open_q, close_q, set_q;
    logic             open_d, close_d, set_d;
    logic             lockout_q, lockout_d;
    logic             open_btn_q, close_btn_q, set_btn_q;
    logic             open_edge, close_edge, set_edge;
`ifdef LOCK_ACCESS_ALARM_EN
    logic             alarm_q, alarm_d;
`endif

    // 0->1 button transitions
    assign open_edge  = bus.OPEN_BTN  & ~open_btn_q;
    assign close_edge = bus.CLOSE_BTN & ~close_btn_q;
    assign set_edge   = bus.SET_BTN   & ~set_btn_q;

    // Next state, counters and strobes; timers expire on the cycle they step 1 -> 0
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        fail_d   = fail_q;
        open_d   = 1'b0;
        close_d  = 1'b0;
        set_d    = 1'b0;
        fail_inc = (fail_q == CNT_W'(MAX_TRIES)) ? fail_q : fail_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (close_edge) begin
                    close_d = 1'b1;
                    timer_d = '0;
                end else if (open_edge) begin
                    open_d  = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (close_edge) begin
                    close_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else if (bus.LOCK_IN) begin
                    fail_d  = '0;
                    timer_d = TMR_W'(AUTO_CLOSE_CYCLES);
                    state_d = ST_UNLOCKED;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == CNT_W'(MAX_TRIES)) begin
`ifdef LOCK_ACCESS_ALARM_EN
                        state_d = ST_ALARM;
`else
                        timer_d = TMR_W'(PENALTY_CYCLES);
                        state_d = ST_PENALTY;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (close_edge) begin
                    close_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    set_d = set_edge;
                    if (bus.KEY_ACT || set_edge) begin
                        timer_d = TMR_W'(AUTO_CLOSE_CYCLES);
                    end else if (AUTO_CLOSE_CYCLES != 0) begin
                        if (timer_q <= TMR_W'(1)) begin
                            close_d = 1'b1;
                            timer_d = '0;
                            state_d = ST_IDLE;
                        end else begin
                            timer_d = timer_q - TMR_W'(1);
                        end
                    end
                end
            end
            ST_PENALTY: begin
                close_d = close_edge;
                if (timer_q <= TMR_W'(1)) begin
                    timer_d = '0;
                    fail_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
`ifdef LOCK_ACCESS_ALARM_EN
            ST_ALARM: begin
                state_d = ST_ALARM;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

`ifdef LOCK_ACCESS_ALARM_EN
        alarm_d   = (state_d == ST_ALARM);
        lockout_d = (state_d == ST_PENALTY) || (state_d == ST_ALARM);
`else
        lockout_d = (state_d == ST_PENALTY);
`endif
    end

    // State, counters, registered outputs and button history
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            fail_q      <= '0;
            open_q      <= 1'b0;
            close_q     <= 1'b0;
            set_q       <= 1'b0;
            lockout_q   <= 1'b0;
            open_btn_q  <= 1'b0;
            close_btn_q <= 1'b0;
            set_btn_q   <= 1'b0;
`ifdef LOCK_ACCESS_ALARM_EN
            alarm_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            fail_q      <= fail_d;
            open_q      <= open_d;
            close_q     <= close_d;
            set_q       <= set_d;
            lockout_q   <= lockout_d;
            open_btn_q  <= bus.OPEN_BTN;
            close_btn_q <= bus.CLOSE_BTN;
            set_btn_q   <= bus.SET_BTN;
`ifdef LOCK_ACCESS_ALARM_EN
            alarm_q     <= alarm_d;
`endif
        end
    end

    assign bus.OPEN_P   = open_q;
    assign bus.CLOSE_P  = close_q;
    assign bus.SET_P    = set_q;
    assign bus.LOCKOUT  = lockout_q;
    assign bus.FAIL_CNT = fail_q;
`ifdef LOCK_ACCESS_ALARM_EN
    assign bus.ALARM    = alarm_q;
`else
    assign bus.ALARM    = 1'b0;
`endif
endmodule

// File: tb/tb_lock_access_sequencer.sv
// Testbench for lock_access_sequencer (MAX_TRIES=3, PENALTY_CYCLES=20, AUTO_CLOSE_CYCLES=50).
// Stimulus pushes each expected strobe (kind, cycle, FAIL_CNT) into a queue; a monitor
// pops and compares whenever any strobe is high. Status outputs are checked inline.
module tb_lock_access_sequencer;
    localparam int K_CLOSE = 0;
    localparam int K_OPEN  = 1;
    localparam int K_SET   = 2;

    typedef struct {
        int kind;
        int cyc;
        int fcnt;
    } exp_t;

    logic CLK;
    logic RESET;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    lock_access_sequencer_if #(.MAX_TRIES(3)) bus();

    lock_access_sequencer #(
        .MAX_TRIES(3),
        .PENALTY_CYCLES(20),
        .AUTO_CLOSE_CYCLES(50),
        .TMR_W(16)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    task automatic push(input int kind, input int at, input int fcnt);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        e.fcnt = fcnt;
        exp_q.push_back(e);
    endtask

    // OPEN press; returns the cycle index at which CHECK has resolved
    task automatic do_open(input logic lock, input int fcnt_before, output int e);
        bus.OPEN_BTN = 1'b1;
        bus.LOCK_IN  = lock;
        push(K_OPEN, cyc + 1, fcnt_before);
        step();
        bus.OPEN_BTN = 1'b0;
        step();
        e = cyc;
    endtask

    task automatic press_close(input int fcnt);
        bus.CLOSE_BTN = 1'b1;
        push(K_CLOSE, cyc + 1, fcnt);
        step();
        bus.CLOSE_BTN = 1'b0;
        step();
    endtask

    // Scoreboard monitor
    initial begin : monitor
        exp_t e;
        int   kind;
        forever begin
            @(negedge CLK);
            if (bus.CLOSE_P || bus.OPEN_P || bus.SET_P) begin
                chk("one_strobe", $countones({bus.CLOSE_P, bus.OPEN_P, bus.SET_P}), 1);
                kind = bus.CLOSE_P ? K_CLOSE : (bus.OPEN_P ? K_OPEN : K_SET);
                chk("strobe_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("strobe_kind", kind, e.kind);
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("strobe_fail_cnt", int'(bus.FAIL_CNT), e.fcnt);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e;
        int lo_cnt;
        int lo_last;
        RESET         = 1'b1;
        bus.OPEN_BTN  = 1'b0;
        bus.CLOSE_BTN = 1'b0;
        bus.SET_BTN   = 1'b0;
        bus.KEY_ACT   = 1'b0;
        bus.LOCK_IN   = 1'b0;
        repeat (3) step();
        chk("reset_lockout", int'(bus.LOCKOUT), 0);
        chk("reset_fail_cnt", int'(bus.FAIL_CNT), 0);
        chk("reset_alarm", int'(bus.ALARM), 0);
        RESET = 1'b0;
        step();

        // Successful open, then auto-close 50 cycles after entering UNLOCKED
        do_open(1'b1, 0, e);
        chk("unlock_fail_cnt", int'(bus.FAIL_CNT), 0);
        push(K_CLOSE, e + 50, 0);
        wait_until(e + 52);

        // KEY_ACT sampled 30 cycles into UNLOCKED pushes the close to cycle 80
        do_open(1'b1, 0, e);
        wait_until(e + 29);
        bus.KEY_ACT = 1'b1;
        step();
        bus.KEY_ACT = 1'b0;
        push(K_CLOSE, e + 80, 0);
        wait_until(e + 82);

        // SET in UNLOCKED, manual close, OPEN+CLOSE together in IDLE, SET in IDLE
        do_open(1'b1, 0, e);
        wait_until(e + 2);
        bus.SET_BTN = 1'b1;
        push(K_SET, cyc + 1, 0);
        step();
        bus.SET_BTN = 1'b0;
        step();
        press_close(0);
        bus.OPEN_BTN  = 1'b1;
        bus.CLOSE_BTN = 1'b1;
        push(K_CLOSE, cyc + 1, 0);
        step();
        bus.OPEN_BTN  = 1'b0;
        bus.CLOSE_BTN = 1'b0;
        step();
        bus.SET_BTN = 1'b1;
        step();
        bus.SET_BTN = 1'b0;
        step();
        step();
        do_open(1'b1, 0, e);
        press_close(0);

        // Two failures then a success clears the count
        do_open(1'b0, 0, e);
        chk("fail_cnt_1", int'(bus.FAIL_CNT), 1);
        do_open(1'b0, 1, e);
        chk("fail_cnt_2", int'(bus.FAIL_CNT), 2);
        do_open(1'b1, 2, e);
        chk("fail_cnt_cleared", int'(bus.FAIL_CNT), 0);
        press_close(0);

`ifndef LOCK_ACCESS_ALARM_EN
        // Three failures -> 20-cycle lockout; OPEN ignored, CLOSE still strobes
        do_open(1'b0, 0, e);
        do_open(1'b0, 1, e);
        do_open(1'b0, 2, e);
        chk("penalty_fail_cnt", int'(bus.FAIL_CNT), 3);
        chk("penalty_alarm", int'(bus.ALARM), 0);
        lo_cnt  = 0;
        lo_last = -1;
        for (int k = 0; k < 25; k++) begin
            if (bus.LOCKOUT) begin
                lo_cnt++;
                lo_last = cyc - e;
            end
            if (k == 2) bus.OPEN_BTN = 1'b1;
            if (k == 3) bus.OPEN_BTN = 1'b0;
            if (k == 5) begin
                bus.CLOSE_BTN = 1'b1;
                push(K_CLOSE, cyc + 1, 3);
            end
            if (k == 6) bus.CLOSE_BTN = 1'b0;
            step();
        end
        chk("lockout_cycles", lo_cnt, 20);
        chk("lockout_last_offset", lo_last, 19);
        chk("post_penalty_fail_cnt", int'(bus.FAIL_CNT), 0);
        chk("post_penalty_lockout", int'(bus.LOCKOUT), 0);
        do_open(1'b1, 0, e);
        press_close(0);

        // RESET ten cycles into PENALTY
        do_open(1'b0, 0, e);
        do_open(1'b0, 1, e);
        do_open(1'b0, 2, e);
        wait_until(e + 10);
        chk("mid_penalty_lockout", int'(bus.LOCKOUT), 1);
        RESET = 1'b1;
        step();
        chk("reset_penalty_lockout", int'(bus.LOCKOUT), 0);
        chk("reset_penalty_fail_cnt", int'(bus.FAIL_CNT), 0);
        RESET = 1'b0;
        step();
        do_open(1'b1, 0, e);
        press_close(0);
`else
        // Three failures -> sticky ALARM; every button ignored until RESET
        do_open(1'b0, 0, e);
        do_open(1'b0, 1, e);
        do_open(1'b0, 2, e);
        chk("alarm_set", int'(bus.ALARM), 1);
        chk("alarm_lockout", int'(bus.LOCKOUT), 1);
        for (int k = 0; k < 100; k++) begin
            bus.OPEN_BTN  = (k % 4 == 0);
            bus.CLOSE_BTN = (k % 4 == 2);
            bus.SET_BTN   = (k % 4 == 2);
            step();
        end
        bus.OPEN_BTN  = 1'b0;
        bus.CLOSE_BTN = 1'b0;
        bus.SET_BTN   = 1'b0;
        chk("alarm_held", int'(bus.ALARM), 1);
        RESET = 1'b1;
        step();
        chk("alarm_cleared", int'(bus.ALARM), 0);
        chk("alarm_reset_lockout", int'(bus.LOCKOUT), 0);
        chk("alarm_reset_fail_cnt", int'(bus.FAIL_CNT), 0);
        RESET = 1'b0;
        step();
`endif

        repeat (5) step();
        chk("pending_strobes", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
